// File: rtl/pll_lock_ctrl_pkg.sv
// Shared state encoding and counter width for the PLL lock sequencer.
package pll_ctrl_pkg;

    localparam int CNT_W = 17;

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL sequencer (master) and the PLL,
// the downstream domain and the status register (slave).
interface pll_lock_ctrl_if;

    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       dom_rst;
    logic       ready;
    logic       fault;
    logic [2:0] retry_cnt;
    logic [2:0] state_o;

    modport master (
        input  pll_lock, relock_req,
        output pll_rst, dom_rst, ready, fault, retry_cnt, state_o
    );

    modport slave (
        output pll_lock, relock_req,
        input  pll_rst, dom_rst, ready, fault, retry_cnt, state_o
    );

endinterface

// File: rtl/pll_lock_ctrl_cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
module cdc_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// Power-up / relock sequencer for the sampling-clock PLL.
// Define PLL_LOCK_CTRL_MONITOR_EN to make RUN fall back to HOLD on sustained lock loss.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC     = 64,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 3
) (
    input  logic            clkin1,
    input  logic            rst,
    pll_lock_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYC);
    localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(LOCK_TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYC);
    localparam logic [CNT_W-1:0] LOSS_LOAD   = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmoSave_q, tmoSave_d;
    logic [2:0]       retry_q, retry_d;
    logic             lockS;

    cdc_sync2 u_lock_sync (
        .clk_i (clkin1),
        .rst_i (rst),
        .d_i   (bus.pll_lock),
        .q_o   (lockS)
    );

    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= HOLD_LOAD;
            tmoSave_q <= TMO_LOAD;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmoSave_q <= tmoSave_d;
            retry_q   <= retry_d;
        end
    end

    // tmoSave holds the unused timeout while STABLE borrows the shared counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmoSave_d = tmoSave_q;
        retry_d   = retry_q;
        if (bus.relock_req) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == ONE) begin
                        state_d = ST_WAIT;
                        cnt_d   = TMO_LOAD;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_WAIT: begin
                    if (lockS) begin
                        state_d   = ST_STABLE;
                        cnt_d     = STABLE_LOAD;
                        tmoSave_d = cnt_q;
                    end else if (cnt_q == ONE) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 3'd1;
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lockS) begin
                        state_d = ST_WAIT;
                        cnt_d   = tmoSave_q;
                    end else if (cnt_q == ONE) begin
                        state_d = ST_RUN;
                        cnt_d   = LOSS_LOAD;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_RUN: begin
`ifdef PLL_LOCK_CTRL_MONITOR_EN
                    if (lockS) begin
                        cnt_d = LOSS_LOAD;
                    end else if (cnt_q == ONE) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        bus.pll_rst   = 1'b0;
        bus.dom_rst   = 1'b1;
        bus.ready     = 1'b0;
        bus.fault     = 1'b0;
        bus.retry_cnt = retry_q;
        bus.state_o   = state_q;
        unique case (state_q)
            ST_HOLD:  bus.pll_rst = 1'b1;
            ST_RUN: begin
                bus.dom_rst = 1'b0;
                bus.ready   = 1'b1;
            end
            ST_FAULT: begin
                bus.pll_rst = 1'b1;
                bus.fault   = 1'b1;
            end
            default:  bus.pll_rst = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed scenarios plus random lock
// behaviour, every cycle compared against a phase/elapsed-time model.
module tb_pll_lock_ctrl;

    localparam int HOLD = 8;
    localparam int TMO  = 100;
    localparam int STAB = 16;
    localparam int MAXR = 2;
    localparam logic [9:0] RESET_VEC = 10'b11_0_0_000_000;

    localparam int S_PRST   = 0;
    localparam int S_RDY    = 1;
    localparam int S_FAULT  = 2;
    localparam int S_STABLE = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pll_lock_ctrl_if bus ();

    pll_lock_ctrl #(
        .RST_HOLD_CYC     (HOLD),
        .LOCK_TIMEOUT_CYC (TMO),
        .LOCK_STABLE_CYC  (STAB),
        .MAX_RETRY        (MAXR)
    ) dut (
        .clkin1 (clk),
        .rst    (rst),
        .bus    (bus)
    );

    // Model: phase 0..4 = HOLD, WAIT, STABLE, RUN, FAULT, with elapsed-time tallies.
    int   mPhase     = 0;
    int   mElapsed   = 0;
    int   mWaitLow   = 0;
    int   mStableRun = 0;
    int   mLowStreak = 0;
    int   mRetries   = 0;
    logic lockD1     = 1'b0;
    logic lockD2     = 1'b0;

    task automatic modelStep();
        logic ls;
        ls = lockD2;
        if (rst) begin
            lockD1 = 1'b0;
            lockD2 = 1'b0;
        end else begin
            lockD2 = lockD1;
            lockD1 = bus.pll_lock;
        end
        if (rst || bus.relock_req) begin
            mPhase   = 0;
            mElapsed = 0;
            mRetries = 0;
        end else begin
            case (mPhase)
                0: begin
                    mElapsed++;
                    if (mElapsed == HOLD) begin
                        mPhase   = 1;
                        mWaitLow = 0;
                    end
                end
                1: begin
                    if (ls) begin
                        mPhase     = 2;
                        mStableRun = 0;
                    end else begin
                        mWaitLow++;
                        if (mWaitLow == TMO) begin
                            if (mRetries < MAXR) begin
                                mRetries++;
                                mPhase   = 0;
                                mElapsed = 0;
                            end else begin
                                mPhase = 4;
                            end
                        end
                    end
                end
                2: begin
                    if (!ls) begin
                        mPhase = 1;
                    end else begin
                        mStableRun++;
                        if (mStableRun == STAB) begin
                            mPhase     = 3;
                            mRetries   = 0;
                            mLowStreak = 0;
                        end
                    end
                end
                3: begin
`ifdef PLL_LOCK_CTRL_MONITOR_EN
                    mLowStreak = ls ? 0 : mLowStreak + 1;
                    if (mLowStreak == 2) begin
                        mPhase   = 0;
                        mElapsed = 0;
                    end
`endif
                end
                default: mPhase = 4;
            endcase
        end
    endtask

    function automatic logic [9:0] expVec();
        logic [9:0] v;
        v = {(mPhase == 0) || (mPhase == 4), mPhase != 3, mPhase == 3, mPhase == 4,
             3'(mRetries), 3'(mPhase)};
        return v;
    endfunction

    function automatic logic [9:0] actVec();
        return {bus.pll_rst, bus.dom_rst, bus.ready, bus.fault, bus.retry_cnt, bus.state_o};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            S_PRST:  return bus.pll_rst;
            S_RDY:   return bus.ready;
            S_FAULT: return bus.fault;
            default: return bus.state_o == 3'd2;
        endcase
    endfunction

    task automatic checkOutput();
        logic [9:0] a, e;
        a = actVec();
        e = expVec();
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL model_compare t=%0t actual=%b required=%b", $time, a, e);
        end
    endtask

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic waitSig(input string name, input int sel, input logic val,
                           input int limit, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkLit(name, 32'(sig(sel) === val), 1);
    endtask

    task automatic measurePulse(output int n);
        n = 0;
        while (bus.pll_rst === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Compare process: model advances on the edge, outputs are checked mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus();
        int   n;
        int   holdLeft;
        logic seen;
        logic visited;
        logic lvl;

        rst            = 1'b1;
        bus.relock_req = 1'b0;
        bus.pll_lock   = 1'b0;
        repeat (3) @(negedge clk);
        checkLit("reset_values", 32'(actVec()), 32'(RESET_VEC));

        // Nominal lock
        rst = 1'b0;
        measurePulse(n);
        checkLit("s1_hold_width", n, HOLD);
        repeat (20) @(negedge clk);
        bus.pll_lock = 1'b1;
        waitSig("s1_ready_reached", S_RDY, 1'b1, 100, n);
        checkLit("s1_ready_latency", n, 2 + 1 + STAB);
        checkLit("s1_retry", 32'(bus.retry_cnt), 0);

        // Lock loss while running
        repeat (5) @(negedge clk);
        bus.pll_lock = 1'b0;
`ifdef PLL_LOCK_CTRL_MONITOR_EN
        n = 0;
        while (!(bus.pll_rst && !bus.ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkLit("s4_loss_reaction_le5", 32'(n <= 5), 1);
        if (n < 5) repeat (5 - n) @(negedge clk);
        bus.pll_lock = 1'b1;
        waitSig("s4_rerun_ready", S_RDY, 1'b1, 200, n);
`else
        seen = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!bus.ready) seen = 1'b0;
        end
        bus.pll_lock = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!bus.ready) seen = 1'b0;
        end
        checkLit("s4_ready_held", 32'(seen), 1);
`endif

        // Relock from RUN, then chatter through STABLE until the timeout fires
        bus.relock_req = 1'b1;
        @(negedge clk);
        bus.relock_req = 1'b0;
        checkLit("relock_next_cycle", 32'({bus.pll_rst, bus.ready}), 32'(2'b10));
        bus.pll_lock = 1'b0;
        waitSig("s3_hold_done", S_PRST, 1'b0, 50, n);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        seen    = 1'b0;
        visited = 1'b0;
        lvl     = 1'b1;
        n       = 0;
        while (bus.retry_cnt == 3'd0 && n < 600) begin
            bus.pll_lock = lvl;
            repeat (5) begin
                @(negedge clk);
                n++;
                if (bus.ready) seen = 1'b1;
                if (sig(S_STABLE)) visited = 1'b1;
            end
            lvl = ~lvl;
        end
        checkLit("s3_no_ready", 32'(seen), 0);
        checkLit("s3_visited_stable", 32'(visited), 1);
        checkLit("s3_timeout_retry", 32'(bus.retry_cnt), 1);

        // No lock at all: three attempts then FAULT
        bus.pll_lock   = 1'b0;
        bus.relock_req = 1'b1;
        @(negedge clk);
        bus.relock_req = 1'b0;
        for (int a = 0; a < 3; a++) begin
            checkLit($sformatf("s2_retry_%0d", a), 32'(bus.retry_cnt), a);
            measurePulse(n);
            checkLit($sformatf("s2_pulse_width_%0d", a), n, HOLD);
            waitSig($sformatf("s2_timeout_%0d", a), S_PRST, 1'b1, TMO + 20, n);
        end
        checkLit("s2_fault", 32'(bus.fault), 1);
        checkLit("s2_retry_final", 32'(bus.retry_cnt), MAXR);
        repeat (10) @(negedge clk);
        checkLit("s2_pll_rst_held", 32'({bus.pll_rst, bus.fault}), 32'(2'b11));

        // Relock out of FAULT, then rst together with relock_req
        bus.relock_req = 1'b1;
        @(negedge clk);
        bus.relock_req = 1'b0;
        checkLit("s5_from_fault", 32'({bus.fault, bus.retry_cnt, bus.state_o}), 0);
        repeat (12) @(negedge clk);
        rst            = 1'b1;
        bus.relock_req = 1'b1;
        @(negedge clk);
        checkLit("s5_rst_and_relock", 32'(actVec()), 32'(RESET_VEC));
        rst            = 1'b0;
        bus.relock_req = 1'b0;

        // Reset in the middle of STABLE
        bus.pll_lock = 1'b1;
        waitSig("s6_reach_stable", S_STABLE, 1'b1, 100, n);
        rst = 1'b1;
        @(negedge clk);
        checkLit("s6_mid_reset", 32'(actVec()), 32'(RESET_VEC));
        rst = 1'b0;

        // Random lock behaviour with sparse relock requests and resets
        holdLeft = 0;
        for (int c = 0; c < 3000; c++) begin
            if (holdLeft == 0) begin
                bus.pll_lock = 1'($urandom_range(0, 1));
                holdLeft     = bus.pll_lock ? $urandom_range(1, 80) : $urandom_range(1, 40);
            end
            holdLeft--;
            bus.relock_req = ($urandom_range(0, 399) == 0);
            rst            = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        rst            = 1'b0;
        bus.relock_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
